// File: rtl/game_pkg.sv
// Shared game constants: spawner FSM encoding, LFSR seed/mask and enemy
// angle/kind widths used by both the spawner and the enemy slots.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEARCH,
        ISSUE
    } spawn_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam int NUM_KINDS = 3;
    localparam int ANGLE_W   = 4;
    localparam int KIND_W    = 2;

    // Raw 2-bit kinds at or above NUM_KINDS fold back to kind 0.
    function automatic logic [KIND_W-1:0] fold_kind(input logic [KIND_W-1:0] raw);
        return (raw >= KIND_W'(NUM_KINDS)) ? '0 : raw;
    endfunction

endpackage

// File: rtl/enemy_spawner_if.sv
// Spawner <-> enemy slot array bundle: per-slot status in, spawn request out.
interface enemy_spawner_if #(
    parameter int NUM_SLOTS = 8
);
    import game_pkg::*;

    logic [NUM_SLOTS-1:0] alive;
    logic [NUM_SLOTS-1:0] killed;
    logic [NUM_SLOTS-1:0] spawn;
    logic [ANGLE_W-1:0]   new_angle;
    logic [KIND_W-1:0]    new_kind;

    modport master (
        input  alive,
        input  killed,
        output spawn,
        output new_angle,
        output new_kind
    );

    modport slave (
        output alive,
        output killed,
        input  spawn,
        input  new_angle,
        input  new_kind
    );

endinterface

// File: rtl/clock.sv
// Free-running prescaler: one-cycle tick every COUNT clk cycles, the first
// one COUNT cycles after reset.
module clock #(
    parameter int COUNT = 3125000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(COUNT - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/enemy_spawner.sv
// Enemy spawner: waits `interval` ticks, picks the next free slot round-robin
// and pulses its spawn line; kills shorten the interval down to a floor.
module enemy_spawner
    import game_pkg::*;
#(
    parameter int NUM_SLOTS     = 8,
    parameter int TICK_COUNT    = 3125000,
    parameter int INIT_INTERVAL = 32,
    parameter int MIN_INTERVAL  = 8,
    parameter int RAMP_KILLS    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    enemy_spawner_if.master        slots,
    output logic [7:0]             interval,
    output logic [15:0]            kill_count
);

    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SW = PW + 1;

    function automatic logic [4:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    spawn_state_t         state;
    logic [PW-1:0]        ptr;
    logic [SW-1:0]        scan;
    logic [7:0]           wait_cnt;
    logic [ANGLE_W-1:0]   last_angle;
    logic [15:0]          lfsr;
    logic [NUM_SLOTS-1:0] killed_q;
    logic [7:0]           ramp_acc;
    logic                 tick;

    logic [NUM_SLOTS-1:0] kill_edge;
    logic [4:0]           kills;
    logic [16:0]          kc_sum;
    logic [8:0]           acc_sum;
    logic [8:0]           acc_sub;
    logic [ANGLE_W-1:0]   pick_angle;
    logic [NUM_SLOTS-1:0] spawn_mask;

    clock #(.COUNT(TICK_COUNT)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign kill_edge  = slots.killed & ~killed_q;
    assign kills      = popcount(kill_edge);
    assign kc_sum     = {1'b0, kill_count} + 17'(kills);
    assign acc_sum    = {1'b0, ramp_acc} + 9'(kills);
    assign acc_sub    = acc_sum - 9'(RAMP_KILLS);
    assign spawn_mask = NUM_SLOTS'(1) << ptr;

    // Bumping a repeated angle by one guarantees consecutive spawns differ.
    assign pick_angle = (lfsr[ANGLE_W-1:0] == last_angle) ? lfsr[ANGLE_W-1:0] + 1'b1
                                                           : lfsr[ANGLE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // Kill tracking runs regardless of FSM state so paused kills still count.
    always_ff @(posedge clk) begin
        if (rst) begin
            killed_q   <= '0;
            kill_count <= '0;
            ramp_acc   <= '0;
            interval   <= 8'(INIT_INTERVAL);
        end else begin
            killed_q   <= slots.killed;
            kill_count <= kc_sum[16] ? 16'hFFFF : kc_sum[15:0];
            if (acc_sum >= 9'(RAMP_KILLS)) begin
                ramp_acc <= acc_sub[8] ? 8'hFF : acc_sub[7:0];
                if (interval > 8'(MIN_INTERVAL)) begin
                    interval <= interval - 8'd1;
                end
            end else begin
                ramp_acc <= acc_sum[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            slots.spawn     <= '0;
            slots.new_angle <= '0;
            slots.new_kind  <= '0;
            ptr             <= '0;
            scan            <= '0;
            wait_cnt        <= '0;
            last_angle      <= '0;
        end else begin
            slots.spawn <= '0;
            if (!enable) begin
                // A pulse already on the wire still advances the bookkeeping.
                state <= IDLE;
                if (state == ISSUE) begin
                    last_angle <= slots.new_angle;
                    ptr        <= ptr + 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        wait_cnt <= interval;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (tick) begin
                            if (wait_cnt > 8'd1) begin
                                wait_cnt <= wait_cnt - 8'd1;
                            end else begin
                                scan  <= '0;
                                state <= SEARCH;
                            end
                        end
                    end
                    SEARCH: begin
                        if (!slots.alive[ptr]) begin
                            slots.new_angle <= pick_angle;
                            slots.new_kind  <= fold_kind(lfsr[5:4]);
                            slots.spawn     <= spawn_mask;
                            state           <= ISSUE;
                        end else begin
                            ptr <= ptr + 1'b1;
                            if (scan == SW'(NUM_SLOTS - 1)) begin
                                wait_cnt <= 8'd1;
                                state    <= WAIT;
                            end else begin
                                scan <= scan + 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        last_angle <= slots.new_angle;
                        ptr        <= ptr + 1'b1;
                        wait_cnt   <= interval;
                        state      <= WAIT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner with a 4-cycle tick, interval 3, floor 1
// and 2 kills per ramp step.
module tb_enemy_spawner;
    import game_pkg::*;

    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  interval;
    logic [15:0] kill_count;

    int checks = 0;
    int errors = 0;

    int         n;
    logic [7:0] seen;
    logic [3:0] prev_angle;
    logic       prev_valid;
    int         spawns;
    int         budget;

    enemy_spawner_if #(.NUM_SLOTS(NS)) bus ();

    enemy_spawner #(
        .NUM_SLOTS     (NS),
        .TICK_COUNT    (4),
        .INIT_INTERVAL (3),
        .MIN_INTERVAL  (1),
        .RAMP_KILLS    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .slots      (bus),
        .interval   (interval),
        .kill_count (kill_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NS-1:0] kill_bits, input int hold);
        bus.killed = kill_bits;
        repeat (hold) @(negedge clk);
        bus.killed = '0;
        @(negedge clk);
    endtask

    // Returns at the negedge where a spawn is seen; seen stays 0 on timeout.
    task automatic waitSpawn(input int limit, output int cnt, output logic [7:0] got);
        got = '0;
        cnt = limit;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.spawn != '0) begin
                got = bus.spawn;
                cnt = i;
                return;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        bus.alive  = '0;
        bus.killed = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_spawn", 32'(bus.spawn), 32'h0);
        checkOutput("rst_angle", 32'(bus.new_angle), 32'h0);
        checkOutput("rst_kind", 32'(bus.new_kind), 32'h0);
        checkOutput("rst_interval", 32'(interval), 32'd3);
        checkOutput("rst_kill_count", 32'(kill_count), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_no_spawn", 32'(bus.spawn), 32'h0);

        // Basic spawning into free slots 0, 1, 2 one interval apart.
        enable = 1'b1;
        waitSpawn(40, n, seen);
        checkOutput("first_spawn", 32'(seen), 32'h01);
        checkOutput("first_latency_ok", 32'(n >= 11 && n <= 14), 32'd1);
        checkOutput("first_kind_ok", 32'(bus.new_kind != 2'd3), 32'd1);
        prev_angle = bus.new_angle;
        @(negedge clk);
        checkOutput("pulse_width", 32'(bus.spawn), 32'h0);
        checkOutput("angle_hold", 32'(bus.new_angle), 32'(prev_angle));
        waitSpawn(40, n, seen);
        checkOutput("second_spawn", 32'(seen), 32'h02);
        checkOutput("second_gap", 32'(n + 1), 32'd12);
        checkOutput("second_angle_diff", 32'(bus.new_angle != prev_angle), 32'd1);
        prev_angle = bus.new_angle;
        waitSpawn(40, n, seen);
        checkOutput("third_spawn", 32'(seen), 32'h04);
        checkOutput("third_gap", 32'(n), 32'd12);
        checkOutput("third_angle_diff", 32'(bus.new_angle != prev_angle), 32'd1);

        // All slots busy, then slot 5 frees up; scan resumes from slot 3.
        bus.alive = 8'hFF;
        waitSpawn(60, n, seen);
        checkOutput("busy_no_spawn", 32'(seen), 32'h0);
        bus.alive = 8'hDF;
        waitSpawn(24, n, seen);
        checkOutput("busy_free5_spawn", 32'(seen), 32'h20);
        bus.alive = 8'hFF;

        // Interval ramp: two kills per step, floor at 1.
        applyStimulus(8'h01, 1);
        applyStimulus(8'h01, 1);
        checkOutput("ramp2_interval", 32'(interval), 32'd2);
        checkOutput("ramp2_kills", 32'(kill_count), 32'd2);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h01, 1);
        checkOutput("ramp4_interval", 32'(interval), 32'd1);
        checkOutput("ramp4_kills", 32'(kill_count), 32'd4);
        applyStimulus(8'h01, 10);
        checkOutput("held_kill_count", 32'(kill_count), 32'd5);
        checkOutput("floor_interval", 32'(interval), 32'd1);

        // Three simultaneous kills from a fresh reset: one step, remainder 1.
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst2_kill_count", 32'(kill_count), 32'd0);
        checkOutput("rst2_interval", 32'(interval), 32'd3);
        rst = 1'b0;
        applyStimulus(8'h16, 1);
        checkOutput("multi_kill_count", 32'(kill_count), 32'd3);
        checkOutput("multi_interval", 32'(interval), 32'd2);
        applyStimulus(8'h80, 1);
        checkOutput("acc_rem_kill_count", 32'(kill_count), 32'd4);
        checkOutput("acc_rem_interval", 32'(interval), 32'd1);

        // Angle/kind invariants over 1000 spawns with random occupancy.
        prev_valid = 1'b0;
        spawns     = 0;
        budget     = 0;
        while (spawns < 1000 && budget < 40000) begin
            @(negedge clk);
            budget++;
            if (bus.spawn != '0) begin
                spawns++;
                checkOutput("rand_kind_ok", 32'(bus.new_kind != 2'd3), 32'd1);
                checkOutput("rand_onehot", 32'($onehot(bus.spawn)), 32'd1);
                if (prev_valid) begin
                    checkOutput("rand_angle_diff", 32'(bus.new_angle != prev_angle), 32'd1);
                end
                prev_angle = bus.new_angle;
                prev_valid = 1'b1;
            end
            bus.alive = 8'($urandom) & 8'($urandom);
        end
        checkOutput("rand_spawn_total", 32'(spawns), 32'd1000);

        // Reset asserted during SEARCH (interval 1: SEARCH is 3 cycles after ISSUE).
        bus.alive = '0;
        waitSpawn(40, n, seen);
        checkOutput("pre_rst_spawn_seen", 32'(seen != 8'h00), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        waitSpawn(4, n, seen);
        checkOutput("rst_search_no_spawn", 32'(seen), 32'h0);
        checkOutput("rst_search_angle", 32'(bus.new_angle), 32'h0);
        checkOutput("rst_search_kind", 32'(bus.new_kind), 32'h0);
        checkOutput("rst_search_interval", 32'(interval), 32'd3);
        checkOutput("rst_search_kill_count", 32'(kill_count), 32'd0);
        rst = 1'b0;
        waitSpawn(40, n, seen);
        checkOutput("post_rst_ptr0", 32'(seen), 32'h01);
        checkOutput("post_rst_latency_ok", 32'(n >= 11 && n <= 14), 32'd1);

        // Pause during WAIT, then resume for a full interval.
        repeat (3) @(negedge clk);
        enable = 1'b0;
        waitSpawn(40, n, seen);
        checkOutput("pause_no_spawn", 32'(seen), 32'h0);
        enable = 1'b1;
        waitSpawn(30, n, seen);
        checkOutput("resume_spawn", 32'(seen), 32'h02);
        checkOutput("resume_latency_ok", 32'(n >= 11 && n <= 14), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
